// File: rtl/dino_pixel_engine_pkg.sv
// -----------------------------------------------------------------------------
// dino_pixel_engine_pkg
// Shared definitions for the dino-run pixel engine: RGB565 colour constants,
// UART key codes, the request FSM state type and the packed game-state record.
// -----------------------------------------------------------------------------
package dino_pixel_engine_pkg;

  // RGB565 palette
  localparam logic [15:0] COLOR_DINO     = 16'h07E0;
  localparam logic [15:0] COLOR_DINO_HIT = 16'hF800;
  localparam logic [15:0] COLOR_OBS      = 16'hF800;
  localparam logic [15:0] COLOR_GROUND   = 16'h0000;
  localparam logic [15:0] COLOR_BG       = 16'hFFFF;
  localparam logic [15:0] COLOR_BG_OVER  = 16'h7BEF;

  // UART key codes
  localparam logic [7:0] KEY_JUMP    = 8'h20;  // space
  localparam logic [7:0] KEY_RESTART = 8'h72;  // 'r'

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PHYS = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Game state stepped once per frame. vel is a two's-complement value.
  typedef struct packed {
    logic [6:0]  dino_h;
    logic [4:0]  vel;
    logic [8:0]  obs_x;
    logic [15:0] score;
  } game_t;

endpackage

// File: rtl/dino_pixel_engine_physics.sv
// -----------------------------------------------------------------------------
// dino_pixel_engine_physics
// Combinational one-frame step of the running game: dino jump/gravity, obstacle
// scroll/respawn, saturating score and the post-step collision test. The caller
// registers the results only on the frame's physics cycle.
// Ports:
//   dino_h_i/vel_i/obs_x_i/score_i  current game state
//   jump_req_i                      pending jump key
//   rnd_i                           respawn distance beyond the right edge
//   dino_h_o/vel_o/obs_x_o/score_o  next game state
//   collision_o                     dino and obstacle overlap after the step
// -----------------------------------------------------------------------------
module dino_pixel_engine_physics
  import dino_pixel_engine_pkg::*;
#(
  parameter int X_MAX  = 160,
  parameter int DINO_X = 16,
  parameter int DINO_W = 8,
  parameter int OBS_W  = 6,
  parameter int OBS_H  = 8,
  parameter int JUMP_V = 6,
  parameter int SPEED  = 2
) (
  input  logic [6:0]  dino_h_i,
  input  logic [4:0]  vel_i,
  input  logic [8:0]  obs_x_i,
  input  logic [15:0] score_i,
  input  logic        jump_req_i,
  input  logic [5:0]  rnd_i,
  output logic [6:0]  dino_h_o,
  output logic [4:0]  vel_o,
  output logic [8:0]  obs_x_o,
  output logic [15:0] score_o,
  output logic        collision_o
);

  logic signed [4:0] vel_eff;
  logic signed [8:0] h_sum;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    dino_h_o    = '0;
    vel_o       = '0;
    obs_x_o     = obs_x_i;
    score_o     = score_i;
    collision_o = 1'b0;

    // A jump only launches from the ground.
    vel_eff = (jump_req_i && (dino_h_i == 7'd0)) ? 5'(JUMP_V) : vel_i;

    // Height is computed signed so a descent past the ground clamps to zero.
    h_sum = $signed({2'b00, dino_h_i}) + $signed({{4{vel_eff[4]}}, vel_eff});
    if (h_sum > 9'sd0) begin
      dino_h_o = h_sum[6:0];
      vel_o    = vel_eff - 5'sd1;
    end

    // Scroll left; once the obstacle would pass column 0, respawn off-screen right.
    if (obs_x_i < 9'(SPEED)) begin
      obs_x_o = 9'(X_MAX) + {3'b000, rnd_i};
    end else begin
      obs_x_o = obs_x_i - 9'(SPEED);
    end

    if (score_i != 16'hFFFF) begin
      score_o = score_i + 16'd1;
    end

    // Horizontal interval overlap plus the obstacle being taller than the dino's lift.
    collision_o = (obs_x_o < 9'(DINO_X + DINO_W)) &&
                  ((obs_x_o + 9'(OBS_W)) > 9'(DINO_X)) &&
                  (dino_h_o < 7'(OBS_H));
  end

endmodule

// File: rtl/dino_pixel_engine.sv
// -----------------------------------------------------------------------------
// dino_pixel_engine
// Game-state and pixel-colour server for the LCD dino-run demo. The panel
// refresh loop pulses update with a pixel coordinate; this block answers with
// the RGB565 colour and a one-cycle done. A request for pixel (0,0) marks the
// start of a frame and first steps the game physics.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   update                1-cycle request for pixel (update_x, update_y)
//   done, done_color      1-cycle answer; colour held until the next answer
//   rnd                   free-running random value (respawn distance)
//   rx_ready, rx_data     received UART byte (space = jump, 'r' = restart)
//   game_over             sticky collision flag
//   score                 frames survived, saturating
// -----------------------------------------------------------------------------
module dino_pixel_engine
  import dino_pixel_engine_pkg::*;
#(
  parameter int X_MAX     = 160,
  parameter int Y_MAX     = 80,
  parameter int RND_WIDTH = 8,
  parameter int GROUND_Y  = 70,
  parameter int DINO_X    = 16,
  parameter int DINO_W    = 8,
  parameter int DINO_H    = 10,
  parameter int OBS_W     = 6,
  parameter int OBS_H     = 8,
  parameter int JUMP_V    = 6,
  parameter int SPEED     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 update,
  input  logic [7:0]           update_x,
  input  logic [6:0]           update_y,
  output logic                 done,
  output logic [15:0]          done_color,
  input  logic [RND_WIDTH-1:0] rnd,
  input  logic                 rx_ready,
  input  logic [7:0]           rx_data,
  output logic                 game_over,
  output logic [15:0]          score
);

  localparam game_t GameInit = '{dino_h: '0, vel: '0, obs_x: 9'(X_MAX - 1), score: '0};

  state_t      state_q, state_d;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  game_t       game_q, game_d;
  logic        game_over_q, game_over_d;
  logic        jump_req_q, jump_req_d;
  logic        restart_req_q, restart_req_d;
  logic        done_q;
  logic [15:0] done_color_q, done_color_d;

  logic [6:0]  phys_dino_h;
  logic [4:0]  phys_vel;
  logic [8:0]  phys_obs_x;
  logic [15:0] phys_score;
  logic        phys_collision;

  logic [8:0]  px, py, ph;
  logic        dino_hit, obs_hit;
  logic [15:0] bg_color, pixel_color;

  // Only the low six bits set the respawn distance.
  logic unused_rnd;
  assign unused_rnd = ^rnd;

  // ---------------------------------------------------------------------------
  // Request FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (update) state_d = ((update_x == 8'd0) && (update_y == 7'd0)) ? S_PHYS : S_EVAL;
      S_PHYS: state_d = S_EVAL;
      S_EVAL: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      // Coordinates are captured only when a request is accepted.
      if ((state_q == S_IDLE) && update) begin
        x_q <= update_x;
        y_q <= update_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Physics step, applied on the frame's physics cycle
  // ---------------------------------------------------------------------------
  dino_pixel_engine_physics #(
    .X_MAX  (X_MAX),
    .DINO_X (DINO_X),
    .DINO_W (DINO_W),
    .OBS_W  (OBS_W),
    .OBS_H  (OBS_H),
    .JUMP_V (JUMP_V),
    .SPEED  (SPEED)
  ) u_physics (
    .dino_h_i    (game_q.dino_h),
    .vel_i       (game_q.vel),
    .obs_x_i     (game_q.obs_x),
    .score_i     (game_q.score),
    .jump_req_i  (jump_req_q),
    .rnd_i       (rnd[5:0]),
    .dino_h_o    (phys_dino_h),
    .vel_o       (phys_vel),
    .obs_x_o     (phys_obs_x),
    .score_o     (phys_score),
    .collision_o (phys_collision)
  );

  always_comb begin
    game_d        = game_q;
    game_over_d   = game_over_q;
    jump_req_d    = jump_req_q;
    restart_req_d = restart_req_q;

    if (state_q == S_PHYS) begin
      // Keys are one-shot: each frame consumes whatever was pending.
      jump_req_d    = 1'b0;
      restart_req_d = 1'b0;
      if (!game_over_q) begin
        game_d = '{dino_h: phys_dino_h, vel: phys_vel, obs_x: phys_obs_x, score: phys_score};
        if (phys_collision) game_over_d = 1'b1;
      end else if (restart_req_q) begin
        game_d      = GameInit;
        game_over_d = 1'b0;
      end
    end

    // A key arriving on the physics cycle is kept for the next frame.
    if (rx_ready && (rx_data == KEY_JUMP))    jump_req_d    = 1'b1;
    if (rx_ready && (rx_data == KEY_RESTART)) restart_req_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Pixel hit-test (9-bit intermediates so the sums never wrap)
  // ---------------------------------------------------------------------------
  always_comb begin
    px = {1'b0, x_q};
    py = {2'b00, y_q};
    ph = {2'b00, game_q.dino_h};

    // Dino rows [GROUND_Y-h-DINO_H, GROUND_Y-h), rearranged to avoid subtraction.
    dino_hit = (px >= 9'(DINO_X)) && (px < 9'(DINO_X + DINO_W)) &&
               ((py + ph + 9'(DINO_H)) >= 9'(GROUND_Y)) &&
               ((py + ph) < 9'(GROUND_Y));

    obs_hit  = (game_q.obs_x < 9'(X_MAX)) &&
               (px >= game_q.obs_x) && (px < (game_q.obs_x + 9'(OBS_W))) &&
               (py >= 9'(GROUND_Y - OBS_H)) && (py < 9'(GROUND_Y));

    bg_color = game_over_q ? COLOR_BG_OVER : COLOR_BG;

    if ((px >= 9'(X_MAX)) || (py >= 9'(Y_MAX))) begin
      pixel_color = bg_color;
    end else if (dino_hit) begin
      pixel_color = game_over_q ? COLOR_DINO_HIT : COLOR_DINO;
    end else if (obs_hit) begin
      pixel_color = COLOR_OBS;
    end else if (py == 9'(GROUND_Y)) begin
      pixel_color = COLOR_GROUND;
    end else begin
      pixel_color = bg_color;
    end
  end

  // The answer is registered at the end of EVAL, so done is high during DONE.
  assign done_color_d = (state_q == S_EVAL) ? pixel_color : done_color_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      game_q        <= GameInit;
      game_over_q   <= 1'b0;
      jump_req_q    <= 1'b0;
      restart_req_q <= 1'b0;
      done_q        <= 1'b0;
      done_color_q  <= '0;
    end else begin
      game_q        <= game_d;
      game_over_q   <= game_over_d;
      jump_req_q    <= jump_req_d;
      restart_req_q <= restart_req_d;
      done_q        <= (state_q == S_EVAL);
      done_color_q  <= done_color_d;
    end
  end

  assign done       = done_q;
  assign done_color = done_color_q;
  assign game_over  = game_over_q;
  assign score      = game_q.score;

endmodule
